data_memory_dp: RTL and testbench
=================================

// Module: data_memory_dp
// PURPOSE
//  Parametrised two-port data memory for the RiSC-16 ASIC; next generation of the single-port data memory.
//  Port 0 serves the core load/store path; port 1 serves the debug/loader path.
//  After reset, a built-in sequencer clears the whole array to CLEAR_VAL, then writes one preload word,
//  before either port may access it. SRAM-macro-style active-low select and write-enable on both ports.
// PARAMETERS
//  DATA_W     16        word width in bits
//  ADDR_W     6         address width; DEPTH = 2**ADDR_W words
//  CLEAR_VAL  16'h0000  value written to every word by the post-reset clear
//  PRE_ADDR   24        address of the preload word, written after the clear
//  PRE_VAL    16'hff8f  value of the preload word
// PORTS
//  clk0      in   1       single clock; all logic on posedge
//  reset     in   1       synchronous, active-high
//  csb0      in   1       port 0 chip select, active low
//  web0      in   1       port 0 write enable, active low (1 = read)
//  addr0     in   ADDR_W  port 0 word address
//  din0      in   DATA_W  port 0 write data
//  dout0     out  DATA_W  port 0 registered read data
//  csb1/web1/addr1/din1/dout1    port 1; same widths and meaning as port 0
//  init_busy out  1       high while reset is asserted or the clear/preload sequence runs; all accesses ignored
//  par_err0  out  1       parity error on the last port-0 read (only with DATA_MEMORY_PARITY_EN)
// BEHAVIOUR
//  Reset: one clock, clk0; reset is synchronous and active-high.
//   While reset is high: dout0 = dout1 = 0, par_err0 = 0, init_busy = 1, state = CLEAR, clr_cnt = 0.
//  FSM states: CLEAR -> PRELOAD -> READY.
//   CLEAR: writes CLEAR_VAL to word clr_cnt each cycle, clr_cnt++.
//     On the cycle clr_cnt == DEPTH-1 the last word is written and the FSM goes to PRELOAD.
//   PRELOAD: one cycle; writes PRE_VAL to PRE_ADDR; goes to READY.
//   READY: normal access; init_busy = 0. READY is left only via reset.
//   The first access is honoured DEPTH+1 cycles after reset falls.
//  Reset mid-sequence: the FSM returns to CLEAR with clr_cnt = 0 and the clear restarts from word 0.
//  Reset in READY: contents are re-cleared by the same sequence.
//  Access (READY only), per port p, on the clock edge:
//   csb_p=0, web_p=1: dout_p <= mem[addr_p]; one-cycle latency.
//   csb_p=0, web_p=0: mem[addr_p] <= din_p; dout_p holds its value.
//   csb_p=1: no access; dout_p holds its value.
//   During init_busy: writes are dropped and dout_p holds its value.
//  Collision rules:
//   Both ports write the same address in one cycle: port 0 wins; the port-1 write is dropped.
//   One port reads an address the other port writes in the same cycle: the read returns the OLD data
//     (read-first); the new data is visible from the next cycle.
//   A port never reads and writes in the same cycle.
//  Addresses are exactly ADDR_W bits, so there is no out-of-range case; clr_cnt wraps only on reset.
// CONFIGURATION
//  DATA_MEMORY_PARITY_EN defined:
//   Array is DATA_W+1 bits wide; bit DATA_W stores the even parity (XOR) of the data bits on every write,
//     including clear and preload writes.
//   On a port-0 read, par_err0 <= stored parity XOR recomputed parity; it holds until the next port-0 read.
//  DATA_MEMORY_PARITY_EN undefined: array is DATA_W bits wide; par_err0 is tied to 0.
// STRUCTURE
//  Package risc16_mem_pkg: localparams for the FSM state encoding (ST_CLEAR, ST_PRELOAD, ST_READY),
//    and function parity().
//  Sub-module data_memory_init_seq: owns the FSM and clr_cnt; outputs init_busy, init_we, init_addr, init_data.
//  Top level: array, port muxing with init_seq having priority, collision logic, output registers.
// TESTING
//  1 reset for 3 cycles, release -> init_busy high exactly DEPTH+1 = 65 cycles; dout0 = dout1 = 0 throughout.
//  2 after init, read port 0 addr 24 and addr 5 -> 16'hff8f then 16'h0000, each one cycle after the request.
//  3 port 0 writes 16'h1234 @ addr 7 while port 1 reads addr 7 in the same cycle -> dout1 = 16'h0000;
//    port 1 re-reads next cycle -> 16'h1234.
//  4 both ports write addr 9 (port 0 16'hAAAA, port 1 16'h5555) -> a later read returns 16'hAAAA.
//  5 assert reset at clear cycle 30, release -> init_busy lasts a full 65 cycles again; word 40 reads 0.
//  6 PARITY_EN: write 16'h0001 @ 3, force-flip stored bit 0 via hierarchical access, read port 0 -> par_err0 = 1;
//    read addr 24 -> par_err0 = 0.

Source files
------------

// File: rtl/risc16_mem_pkg.sv
// Shared types and helpers for the RiSC-16 two-port data memory.
package risc16_mem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_PRELOAD = 2'd1,
    ST_READY   = 2'd2
  } init_state_e;

  // Even parity; callers zero-extend narrower words, which leaves the XOR unchanged.
  function automatic logic parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/data_memory_init_seq.sv
// Post-reset sequencer: clears every word, then writes the single preload word.
module data_memory_init_seq
  import risc16_mem_pkg::*;
#(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 6,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
  parameter int unsigned       PRE_ADDR  = 24,
  parameter logic [DATA_W-1:0] PRE_VAL   = 16'hff8f
) (
  input  logic              clk0,
  input  logic              reset,
  output logic              init_busy,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic [DATA_W-1:0] init_data
);

  init_state_e       state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge clk0) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    init_we   = 1'b0;
    init_addr = clr_cnt_q;
    init_data = CLEAR_VAL;
    unique case (state_q)
      ST_CLEAR: begin
        init_we = 1'b1;
        // Counter parks on the last word; only reset brings it back to zero.
        if (clr_cnt_q == '1) begin
          state_d = ST_PRELOAD;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      ST_PRELOAD: begin
        init_we   = 1'b1;
        init_addr = ADDR_W'(PRE_ADDR);
        init_data = PRE_VAL;
        state_d   = ST_READY;
      end
      ST_READY: begin
      end
      default: state_d = ST_CLEAR;
    endcase
    if (reset) init_we = 1'b0;
  end

  assign init_busy = reset || (state_q != ST_READY);

endmodule

// File: rtl/data_memory_dp.sv
// Two-port RiSC-16 data memory with post-reset clear/preload.
// Optional stored parity with port-0 checking when DATA_MEMORY_PARITY_EN is defined.
module data_memory_dp
  import risc16_mem_pkg::*;
#(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 6,
  parameter logic [DATA_W-1:0] CLEAR_VAL = 16'h0000,
  parameter int unsigned       PRE_ADDR  = 24,
  parameter logic [DATA_W-1:0] PRE_VAL   = 16'hff8f
) (
  input  logic              clk0,
  input  logic              reset,
  input  logic              csb0,
  input  logic              web0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] din0,
  output logic [DATA_W-1:0] dout0,
  input  logic              csb1,
  input  logic              web1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] din1,
  output logic [DATA_W-1:0] dout1,
  output logic              init_busy,
  output logic              par_err0
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef DATA_MEMORY_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0]  mem [DEPTH];
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;
  logic [MEM_W-1:0]  wword_init, wword0, wword1, rword0, rword1;
  logic              we0, we1, re0, re1;

  data_memory_init_seq #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .CLEAR_VAL(CLEAR_VAL),
    .PRE_ADDR (PRE_ADDR),
    .PRE_VAL  (PRE_VAL)
  ) u_init_seq (
    .clk0     (clk0),
    .reset    (reset),
    .init_busy(init_busy),
    .init_we  (init_we),
    .init_addr(init_addr),
    .init_data(init_data)
  );

`ifdef DATA_MEMORY_PARITY_EN
  assign wword_init = {parity(64'(init_data)), init_data};
  assign wword0     = {parity(64'(din0)), din0};
  assign wword1     = {parity(64'(din1)), din1};
`else
  assign wword_init = init_data;
  assign wword0     = din0;
  assign wword1     = din1;
`endif

  assign we0 = !init_busy && !csb0 && !web0;
  assign re0 = !init_busy && !csb0 && web0;
  // Port 0 wins a same-address write collision.
  assign we1 = !init_busy && !csb1 && !web1 && !(we0 && (addr0 == addr1));
  assign re1 = !init_busy && !csb1 && web1;

  assign rword0 = mem[addr0];
  assign rword1 = mem[addr1];

  always_ff @(posedge clk0) begin
    if (init_we) begin
      mem[init_addr] <= wword_init;
    end else begin
      if (we1) mem[addr1] <= wword1;
      if (we0) mem[addr0] <= wword0;
    end
  end

  // Reads sample the array before this edge's writes land: read-first collisions.
  always_ff @(posedge clk0) begin
    if (reset) begin
      dout0 <= '0;
      dout1 <= '0;
    end else begin
      if (re0) dout0 <= rword0[DATA_W-1:0];
      if (re1) dout1 <= rword1[DATA_W-1:0];
    end
  end

`ifdef DATA_MEMORY_PARITY_EN
  always_ff @(posedge clk0) begin
    if (reset) begin
      par_err0 <= 1'b0;
    end else if (re0) begin
      par_err0 <= rword0[DATA_W] ^ parity(64'(rword0[DATA_W-1:0]));
    end
  end
`else
  assign par_err0 = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_dp.sv
// Scoreboard bench for data_memory_dp: init timing, read/write, collisions, reset restart.
module tb_data_memory_dp;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 64;

  logic              clk0 = 1'b0;
  logic              reset = 1'b1;
  logic              csb0 = 1'b1, web0 = 1'b1, csb1 = 1'b1, web1 = 1'b1;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] din0 = '0, din1 = '0;
  logic [DATA_W-1:0] dout0, dout1;
  logic              init_busy, par_err0;

  int unsigned       n_checks = 0;
  int unsigned       n_fail = 0;
  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] last0, last1;
  logic [DATA_W-1:0] exp_q [$];

  data_memory_dp u_dut (
    .clk0     (clk0),
    .reset    (reset),
    .csb0     (csb0),
    .web0     (web0),
    .addr0    (addr0),
    .din0     (din0),
    .dout0    (dout0),
    .csb1     (csb1),
    .web1     (web1),
    .addr1    (addr1),
    .din1     (din1),
    .dout1    (dout1),
    .init_busy(init_busy),
    .par_err0 (par_err0)
  );

  always #5 clk0 = ~clk0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    model[24] = 16'hff8f;
    last0 = '0;
    last1 = '0;
  endtask

  task automatic idle_ports();
    csb0 = 1'b1;
    web0 = 1'b1;
    csb1 = 1'b1;
    web1 = 1'b1;
  endtask

  // One cycle of traffic; expected outputs come from the bench model before writes apply.
  task automatic access(input string tag,
                        input logic c0, input logic w0, input logic [ADDR_W-1:0] a0,
                        input logic [DATA_W-1:0] d0,
                        input logic c1, input logic w1, input logic [ADDR_W-1:0] a1,
                        input logic [DATA_W-1:0] d1);
    logic [DATA_W-1:0] e0, e1;
    e0 = last0;
    e1 = last1;
    if (!c0 && w0) e0 = model[a0];
    if (!c1 && w1) e1 = model[a1];
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    if (!c1 && !w1 && !(!c0 && !w0 && a0 == a1)) model[a1] = d1;
    if (!c0 && !w0) model[a0] = d0;
    csb0 = c0; web0 = w0; addr0 = a0; din0 = d0;
    csb1 = c1; web1 = w1; addr1 = a1; din1 = d1;
    @(posedge clk0);
    #1;
    idle_ports();
    check({tag, "_dout0"}, 32'(dout0), 32'(exp_q.pop_front()));
    check({tag, "_dout1"}, 32'(dout1), 32'(exp_q.pop_front()));
    last0 = e0;
    last1 = e1;
  endtask

  // Counts busy cycles (bounded) while hammering both ports; nothing may get through.
  task automatic run_init(input string tag, input int stop_at, output int n);
    n = 0;
    csb0 = 1'b0; web0 = 1'b1; addr0 = 6'd24;
    csb1 = 1'b0; web1 = 1'b0; addr1 = 6'd2; din1 = 16'hbeef;
    while (init_busy && n < 200 && n != stop_at) begin
      if (dout0 !== '0 || dout1 !== '0) begin
        check({tag, "_dout_busy"}, {dout0, dout1}, 32'h0);
      end
      @(posedge clk0);
      #1;
      n++;
    end
    idle_ports();
    model_reset();
  endtask

  initial begin
    int n;
    logic c0, w0, c1, w1;
    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] d0, d1;

    // Test 1: reset state and init length.
    repeat (3) @(posedge clk0);
    #1;
    check("rst_dout0", 32'(dout0), 32'h0);
    check("rst_dout1", 32'(dout1), 32'h0);
    check("rst_busy", 32'(init_busy), 32'h1);
    check("rst_par", 32'(par_err0), 32'h0);
    reset = 1'b0;
    run_init("init1", -1, n);
    check("init1_len", 32'(n), 32'd65);
    check("init1_dout0", 32'(dout0), 32'h0);
    check("init1_dout1", 32'(dout1), 32'h0);

    // Test 2: preload and cleared word; also the write dropped during init.
    access("t2_a24", 0, 1, 6'd24, 16'h0, 1, 1, 6'd0, 16'h0);
    check("t2_preload", 32'(dout0), 32'h0000ff8f);
    access("t2_a5", 0, 1, 6'd5, 16'h0, 0, 1, 6'd2, 16'h0);
    check("t2_clear", 32'(dout0), 32'h0);
    check("t2_dropped", 32'(dout1), 32'h0);
    check("t2_par", 32'(par_err0), 32'h0);

    // Test 3: read-first collision, then new data visible.
    access("t3_col", 0, 0, 6'd7, 16'h1234, 0, 1, 6'd7, 16'h0);
    check("t3_old", 32'(dout1), 32'h0);
    access("t3_new", 1, 1, 6'd0, 16'h0, 0, 1, 6'd7, 16'h0);
    check("t3_new_val", 32'(dout1), 32'h1234);

    // Test 4: write-write collision, port 0 wins; idle ports hold dout.
    access("t4_ww", 0, 0, 6'd9, 16'haaaa, 0, 0, 6'd9, 16'h5555);
    access("t4_rd", 0, 1, 6'd9, 16'h0, 0, 1, 6'd9, 16'h0);
    check("t4_win0", 32'(dout0), 32'h0000aaaa);
    check("t4_win1", 32'(dout1), 32'h0000aaaa);
    access("t4_hold", 1, 1, 6'd0, 16'h0, 1, 0, 6'd1, 16'h0);
    check("t4_hold0", 32'(dout0), 32'h0000aaaa);

    // Mixed random traffic over a narrow range to provoke collisions.
    for (int i = 0; i < 80; i++) begin
      c0 = ($urandom_range(0, 3) == 0);
      c1 = ($urandom_range(0, 3) == 0);
      w0 = 1'($urandom_range(0, 1));
      w1 = 1'($urandom_range(0, 1));
      a0 = 6'($urandom_range(0, 7));
      a1 = 6'($urandom_range(0, 7));
      d0 = 16'($urandom);
      d1 = 16'($urandom);
      access("rnd", c0, w0, a0, d0, c1, w1, a1, d1);
    end

    // Test 5: reset in READY, then again partway through the clear.
    access("t5_wr", 0, 0, 6'd40, 16'h7777, 1, 1, 6'd0, 16'h0);
    access("t5_chk", 0, 1, 6'd40, 16'h0, 1, 1, 6'd0, 16'h0);
    check("t5_pre", 32'(dout0), 32'h7777);
    reset = 1'b1;
    @(posedge clk0);
    #1;
    check("t5_rst_dout0", 32'(dout0), 32'h0);
    reset = 1'b0;
    run_init("init2a", 30, n);
    check("t5_mid_busy", 32'(init_busy), 32'h1);
    reset = 1'b1;
    @(posedge clk0);
    #1;
    reset = 1'b0;
    run_init("init2", -1, n);
    check("init2_len", 32'(n), 32'd65);
    access("t5_w40", 0, 1, 6'd40, 16'h0, 0, 1, 6'd24, 16'h0);
    check("t5_w40_val", 32'(dout0), 32'h0);
    check("t5_a24_val", 32'(dout1), 32'h0000ff8f);

`ifdef DATA_MEMORY_PARITY_EN
    // Test 6: corrupt a stored bit behind the parity bit's back.
    access("t6_wr", 0, 0, 6'd3, 16'h0001, 1, 1, 6'd0, 16'h0);
    u_dut.mem[3][0] = ~u_dut.mem[3][0];
    model[3] = 16'h0000;
    access("t6_rd", 0, 1, 6'd3, 16'h0, 1, 1, 6'd0, 16'h0);
    check("t6_err", 32'(par_err0), 32'h1);
    access("t6_hold", 1, 1, 6'd0, 16'h0, 0, 1, 6'd24, 16'h0);
    check("t6_err_hold", 32'(par_err0), 32'h1);
    access("t6_ok", 0, 1, 6'd24, 16'h0, 1, 1, 6'd0, 16'h0);
    check("t6_clean", 32'(par_err0), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
